// File: rtl/io_port_bank_if.sv
// rtl/io_port_bank_if.sv - CPU-side address/strobe bus with registered read return
interface io_port_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output addr, wdata, write, read,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, wdata, write, read,
        output rdata, rvalid
    );
endinterface

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - output regs, synchronised inputs and edge-trap bank; IO_TRAP_MASK_EN adds a trap MASK register
module io_port_bank #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int N_OUT       = 2,
    parameter int N_IN        = 2,
    parameter int N_TRAP      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    async_nreset,
    io_port_bank_if.slave           bus,
    input  logic [N_IN*DATA_W-1:0]  io_in,
    output logic [N_OUT*DATA_W-1:0] io_out,
    input  logic [N_TRAP-1:0]       trap_in,
    output logic                    trap_req
);
    localparam int EVT = N_OUT + N_IN;

    logic [SYNC_STAGES-1:0][N_IN*DATA_W-1:0] in_sync_q;
    logic [SYNC_STAGES-1:0][N_TRAP-1:0]      trap_sync_q;
    logic [N_TRAP-1:0]       trap_prev_q;
    logic [N_TRAP-1:0]       pending_q, pending_d;
    logic [N_TRAP-1:0]       trap_rise, evt_clr, enable;
    logic [N_OUT*DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    rvalid_q;
    int                      addr_n;

    assign addr_n = int'(bus.addr);

    assign trap_rise = trap_sync_q[SYNC_STAGES-1] & ~trap_prev_q;
    assign evt_clr   = (bus.write && addr_n == EVT) ? bus.wdata[N_TRAP-1:0] : '0;
    // A rising edge landing on the same edge as a clear must survive.
    assign pending_d = (pending_q & ~evt_clr) | trap_rise;

`ifdef IO_TRAP_MASK_EN
    localparam int MASK_ADDR = EVT + 1;
    logic [N_TRAP-1:0] mask_q;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            mask_q <= '1;
        end else if (bus.write && addr_n == MASK_ADDR) begin
            mask_q <= bus.wdata[N_TRAP-1:0];
        end
    end

    assign enable = mask_q;
`else
    assign enable = '1;
`endif

    always_comb begin
        out_d = out_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (bus.write && addr_n == k) begin
                out_d[k*DATA_W +: DATA_W] = bus.wdata;
            end
        end
    end

    // Read mux sees pre-write register values, so a same-cycle write is not forwarded.
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (addr_n == k) rdata_d = out_q[k*DATA_W +: DATA_W];
        end
        for (int j = 0; j < N_IN; j++) begin
            if (addr_n == N_OUT + j) rdata_d = in_sync_q[SYNC_STAGES-1][j*DATA_W +: DATA_W];
        end
        if (addr_n == EVT) rdata_d = DATA_W'(pending_q);
`ifdef IO_TRAP_MASK_EN
        if (addr_n == MASK_ADDR) rdata_d = DATA_W'(mask_q);
`endif
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            in_sync_q   <= '0;
            trap_sync_q <= '0;
            trap_prev_q <= '0;
            pending_q   <= '0;
            out_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            in_sync_q   <= {in_sync_q[SYNC_STAGES-2:0], io_in};
            trap_sync_q <= {trap_sync_q[SYNC_STAGES-2:0], trap_in};
            trap_prev_q <= trap_sync_q[SYNC_STAGES-1];
            pending_q   <= pending_d;
            out_q       <= out_d;
            rvalid_q    <= bus.read;
            if (bus.read) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign io_out     = out_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign trap_req   = |(pending_q & enable);
endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - directed self-checking bench for io_port_bank
module tb_io_port_bank;
    logic        clk = 1'b0;
    logic        async_nreset = 1'b0;
    logic [15:0] io_in = '0;
    logic [15:0] io_out;
    logic [1:0]  trap_in = '0;
    logic        trap_req;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  rd;
    logic        rv;

    io_port_bank_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    io_port_bank #(
        .DATA_W(8), .ADDR_W(4), .N_OUT(2), .N_IN(2), .N_TRAP(2), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .async_nreset(async_nreset),
        .bus(bus),
        .io_in(io_in),
        .io_out(io_out),
        .trap_in(trap_in),
        .trap_req(trap_req)
    );

    always #5 clk = ~clk;

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        bus.addr = a; bus.wdata = d; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d, output logic v);
        bus.addr = a; bus.read = 1'b1;
        @(negedge clk);
        d = bus.rdata; v = bus.rvalid;
        bus.read = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (io_out !== 16'h0000) begin bad++; $display("FAIL reset_io_out got=%0h exp=0", io_out); end
        total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", bus.rdata); end
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0h exp=0", bus.rvalid); end
        total++; if (trap_req !== 1'b0) begin bad++; $display("FAIL reset_trap_req got=%0h exp=0", trap_req); end
    endtask

    task automatic test_out_reg;
        cpu_write(4'd1, 8'hA5);
        total++; if (io_out !== 16'hA500) begin bad++; $display("FAIL out1_write got=%0h exp=a500", io_out); end
        cpu_read(4'd1, rd, rv);
        total++; if (rd !== 8'hA5) begin bad++; $display("FAIL out1_read got=%0h exp=a5", rd); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL out1_rvalid got=%0h exp=1", rv); end
        @(negedge clk);
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_drop got=%0h exp=0", bus.rvalid); end
        total++; if (bus.rdata !== 8'hA5) begin bad++; $display("FAIL rdata_hold got=%0h exp=a5", bus.rdata); end
        cpu_write(4'hF, 8'h77);
        total++; if (io_out !== 16'hA500) begin bad++; $display("FAIL unmapped_write got=%0h exp=a500", io_out); end
        cpu_read(4'hF, rd, rv);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL unmapped_read got=%0h exp=0", rd); end
        cpu_write(4'd0, 8'h5A);
        bus.addr = 4'd0; bus.wdata = 8'hC3; bus.write = 1'b1; bus.read = 1'b1;
        @(negedge clk);
        bus.write = 1'b0; bus.read = 1'b0;
        total++; if (bus.rdata !== 8'h5A) begin bad++; $display("FAIL rw_same_addr_rdata got=%0h exp=5a", bus.rdata); end
        total++; if (io_out !== 16'hA5C3) begin bad++; $display("FAIL rw_same_addr_out got=%0h exp=a5c3", io_out); end
    endtask

    task automatic test_in_port;
        io_in = 16'h3C11;
        repeat (5) @(negedge clk);
        cpu_read(4'd3, rd, rv);
        total++; if (rd !== 8'h3C) begin bad++; $display("FAIL in1_read got=%0h exp=3c", rd); end
        cpu_read(4'd2, rd, rv);
        total++; if (rd !== 8'h11) begin bad++; $display("FAIL in0_read got=%0h exp=11", rd); end
        cpu_write(4'd3, 8'hEE);
        cpu_read(4'd3, rd, rv);
        total++; if (rd !== 8'h3C) begin bad++; $display("FAIL in1_write_ignored got=%0h exp=3c", rd); end
        total++; if (io_out !== 16'hA5C3) begin bad++; $display("FAIL in_write_out got=%0h exp=a5c3", io_out); end
        io_in = 16'h5511;
        @(negedge clk);
        cpu_read(4'd3, rd, rv);
        total++; if (rd !== 8'h3C) begin bad++; $display("FAIL in1_sync_delay got=%0h exp=3c", rd); end
        repeat (3) @(negedge clk);
        cpu_read(4'd3, rd, rv);
        total++; if (rd !== 8'h55) begin bad++; $display("FAIL in1_new_value got=%0h exp=55", rd); end
    endtask

    task automatic test_trap_edge;
        trap_in[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (trap_req !== 1'b0) begin bad++; $display("FAIL trap_early got=%0h exp=0", trap_req); end
        @(negedge clk);
        total++; if (trap_req !== 1'b1) begin bad++; $display("FAIL trap_on_time got=%0h exp=1", trap_req); end
        repeat (5) @(negedge clk);
        cpu_read(4'd4, rd, rv);
        total++; if (rd !== 8'h01) begin bad++; $display("FAIL trap_pending got=%0h exp=01", rd); end
        cpu_write(4'd4, 8'h01);
        total++; if (trap_req !== 1'b0) begin bad++; $display("FAIL trap_clear got=%0h exp=0", trap_req); end
        repeat (3) @(negedge clk);
        total++; if (trap_req !== 1'b0) begin bad++; $display("FAIL trap_single_event got=%0h exp=0", trap_req); end
        cpu_read(4'd4, rd, rv);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL trap_pending_after_clear got=%0h exp=0", rd); end
        trap_in[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_collision;
        trap_in[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.addr = 4'd4; bus.wdata = 8'h02; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
        total++; if (trap_req !== 1'b1) begin bad++; $display("FAIL collision_trap_req got=%0h exp=1", trap_req); end
        cpu_read(4'd4, rd, rv);
        total++; if (rd !== 8'h02) begin bad++; $display("FAIL collision_pending got=%0h exp=02", rd); end
        trap_in[1] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_async_reset;
        cpu_write(4'd1, 8'hFF);
        bus.addr = 4'd1; bus.read = 1'b1;
        @(posedge clk);
        #2;
        async_nreset = 1'b0;
        #1;
        total++; if (io_out !== 16'h0000) begin bad++; $display("FAIL areset_io_out got=%0h exp=0", io_out); end
        total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL areset_rdata got=%0h exp=0", bus.rdata); end
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL areset_rvalid got=%0h exp=0", bus.rvalid); end
        total++; if (trap_req !== 1'b0) begin bad++; $display("FAIL areset_trap_req got=%0h exp=0", trap_req); end
        bus.read = 1'b0;
        repeat (2) @(negedge clk);
        async_nreset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef IO_TRAP_MASK_EN
    task automatic test_mask;
        cpu_read(4'd5, rd, rv);
        total++; if (rd !== 8'h03) begin bad++; $display("FAIL mask_reset got=%0h exp=03", rd); end
        cpu_write(4'd5, 8'h00);
        cpu_read(4'd5, rd, rv);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL mask_write got=%0h exp=0", rd); end
        trap_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        trap_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (trap_req !== 1'b0) begin bad++; $display("FAIL masked_trap_req got=%0h exp=0", trap_req); end
        cpu_read(4'd4, rd, rv);
        total++; if (rd !== 8'h01) begin bad++; $display("FAIL masked_pending got=%0h exp=01", rd); end
        cpu_write(4'd5, 8'h01);
        total++; if (trap_req !== 1'b1) begin bad++; $display("FAIL unmask_trap_req got=%0h exp=1", trap_req); end
    endtask
`else
    task automatic test_mask;
        cpu_write(4'd5, 8'hFF);
        cpu_read(4'd5, rd, rv);
        total++; if (rd !== 8'h00) begin bad++; $display("FAIL evt_plus1_unmapped got=%0h exp=0", rd); end
        total++; if (trap_req !== 1'b0) begin bad++; $display("FAIL evt_plus1_trap_req got=%0h exp=0", trap_req); end
        total++; if (io_out !== 16'h0000) begin bad++; $display("FAIL evt_plus1_io_out got=%0h exp=0", io_out); end
    endtask
`endif

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.write = 1'b0; bus.read = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        async_nreset = 1'b1;
        @(negedge clk);
        test_out_reg();
        test_in_port();
        test_trap_edge();
        test_collision();
        test_async_reset();
        test_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
Parametrised memory-mapped I/O block between the CPU and the outside pins. It replaces the single 8-bit output latch and single exit-trap edge detector with a bank of:
- N_OUT writable output registers.
- N_IN synchronised input ports.
- N_TRAP edge-detected trap sources, with sticky pending bits and a write-one-to-clear handshake.

The CPU reaches the block through a small address/strobe bus with a registered read path.

Parameters:
DATA_W, 8, width of every data port and register
ADDR_W, 4, width of the CPU address bus; must satisfy 2**ADDR_W >= N_OUT+N_IN+2
N_OUT, 2, number of output registers
N_IN, 2, number of input ports
N_TRAP, 2, number of trap sources; must be 1..DATA_W
SYNC_STAGES, 2, flip-flop stages on every external input (min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
async_nreset  input  1  asynchronous active-low reset
addr  input  ADDR_W  CPU register address
wdata  input  DATA_W  CPU write data
write  input  1  write strobe, one access per cycle
read  input  1  read strobe
rdata  output  DATA_W  registered read data
rvalid  output  1  high the cycle rdata is valid
io_in  input  N_IN*DATA_W  external input ports, asynchronous to clk
io_out  output  N_OUT*DATA_W  output register contents, port k at bits [k*DATA_W +: DATA_W]
trap_in  input  N_TRAP  external trap lines, asynchronous to clk
trap_req  output  1  OR of enabled pending trap bits

Behaviour:
- Reset (async assert, sync release): all output regs 0, all sync/edge flops 0, pending 0, rdata 0, rvalid 0, trap_req 0.
- Address map:
  - 0..N_OUT-1: OUT[k], read/write.
  - N_OUT..N_OUT+N_IN-1: IN[j], read-only synchronised io_in value.
  - EVT = N_OUT+N_IN: pending bits in [N_TRAP-1:0], upper bits read 0.
  - EVT+1: MASK, only with the optional feature.
  - Any other address is unmapped: reads return 0, writes are ignored.
- Write to OUT[k]: io_out port k takes wdata on the same clock edge, so it is visible the next cycle.
- Write to IN[j]: ignored.
- Write to EVT: write-one-to-clear. For each bit i, pending[i] <= 0 where wdata[i]=1; bits written 0 are unchanged.
- Read: on the edge where read=1, rdata is loaded with the addressed value and rvalid is driven to 1.
  - Latency is 1 cycle.
  - rvalid falls the cycle after read drops.
  - rdata holds its last value while read=0.
- Simultaneous read and write to the same address: rdata returns the pre-write value.
- Input path: each io_in and trap_in bit passes through SYNC_STAGES flops. An additional flop per trap bit holds the previous synchronised value for edge detection.
- Trap rising edge: when sync[i]=1 and prev[i]=0, pending[i] is set on the next edge.
  - The pending bit is visible SYNC_STAGES+1 edges after the first clock edge that samples trap_in[i] high.
  - A trap line held high produces exactly one event; a new event requires low-then-high.
  - A level change shorter than one clock period may be missed; callers must hold for at least 2 cycles.
- Simultaneous set and clear of the same pending bit in the same cycle: set wins, so the bit stays 1 and no event is lost.
- trap_req = |(pending & enable), derived combinationally from registers only (no input-to-output combinational path).
  - enable is all-ones without the optional feature.
- Reset mid-operation clears pending events and output values immediately, with no glitch-free guarantee on io_out.

Optional Feature:
Macro IO_TRAP_MASK_EN.
- Defined:
  - Adds a MASK register at address EVT+1, read/write, N_TRAP bits wide, upper bits read 0.
  - MASK resets to all-ones.
  - enable = MASK.
  - Masked sources still set pending, so unmasking a set pending bit raises trap_req the next cycle after the MASK write.
- Not defined:
  - Address EVT+1 is unmapped.
  - enable is all-ones.
  - No MASK flops exist.

Test Plan:
- Reset: async_nreset low mid-cycle -> io_out=0, rdata=0, rvalid=0, trap_req=0 immediately, before the next clock edge.
- Output register: write addr=1 wdata=0xA5 -> io_out[15:8]=0xA5 the next cycle. Read addr=1 -> rdata=0xA5 with rvalid=1 one cycle later. Write addr=0xF (unmapped) -> no change anywhere.
- Input port: io_in port 1 = 0x3C, held 5 cycles, then read addr=3 -> rdata=0x3C. A change to 0x55 read SYNC_STAGES-1 cycles later still returns 0x3C.
- Trap edge: trap_in[0] rises and is held high for 10 cycles -> pending=0x01 and trap_req=1 exactly SYNC_STAGES+1 edges after the first sampling edge, with a single event only. Write EVT wdata=0x01 -> trap_req=0 the next cycle.
- Set/clear collision: time a write EVT wdata=0x02 on the same edge that trap_in[1]'s edge sets pending -> read EVT returns 0x02 and trap_req stays 1.
- IO_TRAP_MASK_EN: write MASK=0x00, then pulse trap_in[0] -> pending=0x01 with trap_req=0. Write MASK=0x01 -> trap_req=1 the next cycle. Without the macro, read addr EVT+1 returns 0.
